// File: rtl/one_to_8_pkg.sv
// Shared types and constants for the 1-to-8 registered demultiplexer.
package one_to_8_pkg;

    localparam int NCH = 8;
    localparam int W   = 3;

    typedef logic [2:0]   ch_idx_t;
    typedef logic [W-1:0] word_t;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } route_mode_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel with valid/ready drain.
module demux_slot #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load wins over a drain: the new word replaces the departing one with no bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/one_to_8_demux_buf.sv
// Registered 1-to-8 demultiplexer: explicit or round-robin target, one buffer per channel.
module one_to_8_demux_buf #(
    parameter int W   = 3,
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     sel,
    input  logic           rr_mode,
    output logic [NCH*W-1:0] out_data,
    output logic [NCH-1:0] out_valid,
    input  logic [NCH-1:0] out_ready,
    output logic [2:0]     rr_ptr
);

    import one_to_8_pkg::ch_idx_t;
    import one_to_8_pkg::route_mode_e;
    import one_to_8_pkg::MODE_RR;

    route_mode_e    mode;
    ch_idx_t        target;
    ch_idx_t        rr_ptr_q, rr_ptr_d;
    logic           accept;
    logic [NCH-1:0] load;

    assign mode   = route_mode_e'(rr_mode);
    assign target = (mode == MODE_RR) ? rr_ptr_q : sel;

    // Ready looks only at the target channel; non-target drains never gate the input.
    assign in_ready = ~out_valid[target] | out_ready[target];
    assign accept   = in_valid & in_ready;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        load = '0;
        if (accept) begin
            load[target] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && mode == MODE_RR) begin
            rr_ptr_d = rr_ptr_q + ch_idx_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .data      (out_data[k*W +: W]),
            .valid     (out_valid[k])
        );
    end

endmodule

// File: tb/tb_one_to_8_demux_buf.sv
// Scoreboard bench: per-channel expected-word queues filled on accept, drained by a monitor.
module tb_one_to_8_demux_buf;

    localparam int W   = 3;
    localparam int NCH = 8;

    logic             clk;
    logic             rst;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic             rr_mode;
    logic [NCH*W-1:0] out_data;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ready;
    logic [2:0]       rr_ptr;

    int checks   = 0;
    int failures = 0;

    // Reference model: one FIFO of expected words per channel plus a plain pointer count.
    logic [W-1:0] exp_q [NCH][$];
    int           m_ptr = 0;

    one_to_8_demux_buf #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares every occupied channel against its queue head and pops on drain.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NCH; k++) begin
                    check($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(exp_q[k].size() != 0));
                    if (exp_q[k].size() != 0) begin
                        check($sformatf("out_data[%0d]", k), int'(out_data[k*W +: W]), int'(exp_q[k][0]));
                        if (out_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus, entered and left just after a rising edge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                               input logic m, input logic [NCH-1:0] ordy);
        int  t;
        bit  exp_rdy;
        bit  acc;
        in_valid  = v;
        in_data   = d;
        sel       = s;
        rr_mode   = m;
        out_ready = ordy;
        @(negedge clk);
        t       = m ? m_ptr : int'(s);
        exp_rdy = (exp_q[t].size() == 0) || (ordy[t] == 1'b1);
        check("in_ready", int'(in_ready), int'(exp_rdy));
        check("rr_ptr", int'(rr_ptr), m_ptr);
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q[t].push_back(d);
            if (m) m_ptr = (m_ptr + 1) % NCH;
        end
    endtask

    task automatic idle_cycles(input int n, input logic [NCH-1:0] ordy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, rr_mode, ordy);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst rr_ptr", int'(rr_ptr), 0);
        for (int k = 0; k < NCH; k++) exp_q[k].delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; sel = '0; rr_mode = 1'b0; out_ready = '0;
        @(posedge clk);
        #1;
        apply_reset();

        // Explicit routing with every consumer ready.
        drive_cycle(1'b1, 3'b101, 3'd0, 1'b0, 8'hFF);
        drive_cycle(1'b1, 3'b010, 3'd3, 1'b0, 8'hFF);
        drive_cycle(1'b1, 3'b111, 3'd7, 1'b0, 8'hFF);
        idle_cycles(2, 8'hFF);

        // Round-robin wrap: ten words over channels 0..7,0,1.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 3'(i), 3'd0, 1'b1, 8'hFF);
        check("rr wrap ptr", int'(rr_ptr), 2);
        idle_cycles(2, 8'hFF);

        // Back-pressure on channel 4, then a same-cycle drain+accept swap.
        drive_cycle(1'b1, 3'b001, 3'd4, 1'b0, 8'hEF);
        drive_cycle(1'b1, 3'b110, 3'd4, 1'b0, 8'hEF);
        drive_cycle(1'b1, 3'b110, 3'd4, 1'b0, 8'hEF);
        drive_cycle(1'b1, 3'b110, 3'd4, 1'b0, 8'hFF);
        drive_cycle(1'b0, 3'b000, 3'd4, 1'b0, 8'hEF);
        check("swap valid4", int'(out_valid[4]), 1);
        check("swap data4", int'(out_data[4*W +: W]), 6);
        idle_cycles(2, 8'hFF);

        // Round-robin stall without skip: pointer 3 parked on a full channel 3.
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 3'(i + 1), 3'd0, 1'b1, 8'hFF);
        drive_cycle(1'b1, 3'b100, 3'd3, 1'b0, 8'hF7);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 3'b011, 3'd0, 1'b1, 8'hF7);
        check("stall ptr", int'(rr_ptr), 3);
        check("stall in_ready", int'(in_ready), 0);
        drive_cycle(1'b1, 3'b011, 3'd0, 1'b1, 8'hFF);
        check("unstall ptr", int'(rr_ptr), 4);
        idle_cycles(2, 8'hFF);

        // Mode switch keeps the pointer: channels 0, 1, 6, 2 in that order.
        apply_reset();
        drive_cycle(1'b1, 3'b001, 3'd0, 1'b1, 8'hFF);
        drive_cycle(1'b1, 3'b010, 3'd0, 1'b1, 8'hFF);
        drive_cycle(1'b1, 3'b011, 3'd6, 1'b0, 8'hFF);
        drive_cycle(1'b1, 3'b100, 3'd6, 1'b1, 8'hFF);
        check("mode sw ptr", int'(rr_ptr), 3);
        idle_cycles(2, 8'hFF);

        // Reset mid-stream with channels 2 and 5 holding words.
        drive_cycle(1'b1, 3'b110, 3'd2, 1'b0, 8'h00);
        drive_cycle(1'b1, 3'b011, 3'd5, 1'b0, 8'h00);
        #2;
        apply_reset();
        drive_cycle(1'b0, 3'b000, 3'd2, 1'b0, 8'h00);
        check("post-rst in_ready", int'(in_ready), 1);
        drive_cycle(1'b1, 3'b101, 3'd5, 1'b1, 8'hFF);

        // Randomized traffic with mixed modes and sparse consumer readiness.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
                        1'($urandom_range(0, 1)), 8'($urandom & $urandom));
        end

        idle_cycles(4, 8'hFF);
        for (int k = 0; k < NCH; k++) check($sformatf("final empty[%0d]", k), exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/one_to_8_demux_buf.md
# one_to_8_demux_buf

Registered 1-to-8 demultiplexer: routes a stream of 3-bit words from one source to one of eight destination channels, each with a one-entry holding buffer and valid/ready handshake. It is the distribution counterpart of the 8-to-1 bus selector in the synth datapath, fanning one control/voice bus out to eight consumers. Target channel comes from an explicit select input or from an internal round-robin pointer.

## Interface
Parameters:
- W, 3, data width of every word and channel.
- NCH, 8, number of output channels; fixed at 8 in this revision, so the select and pointer are 3 bits.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  word to route.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  the word is accepted this cycle when in_valid is also high.
- sel  input  3  target channel in explicit mode.
- rr_mode  input  1  0 = explicit (use sel), 1 = round-robin (use internal pointer).
- out_data  output  NCH*W  packed channel buffers; channel k occupies bits [k*W +: W].
- out_valid  output  NCH  channel k buffer holds a word.
- out_ready  input  NCH  consumer k takes its word this cycle when out_valid[k] is high.
- rr_ptr  output  3  current round-robin pointer, for status and debug.

## Operation
- Target channel t = rr_mode ? rr_ptr : sel. The target is evaluated every cycle.
- in_ready = ~out_valid[t] | out_ready[t]. This is combinational from rr_mode, sel, out_ready and state. in_ready does not depend on in_valid.
- Accept: when in_valid & in_ready, buffer t loads in_data and out_valid[t] is set to 1.
- Drain: when out_valid[k] & out_ready[k] and no accept targets channel k, out_valid[k] clears to 0. out_data[k] keeps its last value after a drain; it is only meaningful while out_valid[k] is high.
- Simultaneous drain and accept on the same channel: the new word replaces the old one and out_valid[k] stays 1. No bubble is inserted.
- Drains on non-target channels proceed independently and in parallel with any accept.
- Round-robin pointer:
  - Increments by 1 modulo 8 (7 wraps to 0) on each accept made while rr_mode is 1.
  - Holds its value when there is no accept or when rr_mode is 0.
  - There is no skipping: if the pointed-to channel is full and not draining, the input stalls.
- Switching rr_mode takes effect in the same cycle. The pointer value is retained across mode changes.
- sel changes while stalled are allowed; in_ready re-evaluates against the new target immediately.
- No data is ever dropped or duplicated. Each accepted word appears exactly once on exactly one channel.

## Timing
- Reset (asynchronous assert, released synchronously to clk) sets:
  - out_valid = 0
  - out_data = 0
  - rr_ptr = 0
- While rst is high, in_ready is 1 only by its formula, but no accept takes effect.
- Reset mid-transfer discards all buffered words. The first accept after reset in round-robin mode goes to channel 0.
- Latency: a word accepted at edge n is visible on out_data/out_valid of its channel immediately after edge n (1 cycle).
- Throughput: 1 word per cycle sustained whenever the target channel is empty or draining in that cycle.
- out_data and out_valid are registered outputs.
- in_ready and the target selection are combinational. The upstream block must not make in_valid depend on in_ready.

## Structure
- Shared package one_to_8_pkg holds:
  - localparam NCH = 8 and W = 3
  - typedef ch_idx_t (3-bit channel index)
  - typedef word_t (W bits)
  - enum route_mode_e: MODE_SEL = 0, MODE_RR = 1
- Sub-module demux_slot: the one-entry holding register for one channel.
  - Inputs: clk, rst, load, load_data, out_ready.
  - Outputs: data, valid.
  - Instantiated NCH times via generate.
- The top level contains target selection, in_ready generation, load decode (one-hot of t gated by the accept) and the pointer register.

## Test plan
- Reset/idle: assert rst mid-stream with channels 2 and 5 full -> all out_valid = 0, out_data = 0, rr_ptr = 0 immediately; in_ready = 1 after release.
- Explicit routing: rr_mode = 0, out_ready = 0xFF, send sel/data pairs 0/3'b101, 3/3'b010, 7/3'b111 on consecutive cycles -> each word appears on its channel one cycle later; no other out_valid bit pulses.
- Round-robin wrap: rr_mode = 1, out_ready = 0xFF, send 10 words 0..7,0,1 -> they land on channels 0..7,0,1 in order; rr_ptr = 2 at the end.
- Back-pressure: rr_mode = 0, sel = 4, out_ready[4] = 0, send 3'b001 then 3'b110 -> in_ready drops after the first accept; the second word is held. Raising out_ready[4] for one cycle swaps in 3'b110 with out_valid[4] staying 1.
- Round-robin stall without skip: rr_ptr = 3 with channel 3 full and out_ready[3] = 0, all other channels empty -> in_ready = 0 and rr_ptr stays 3 until channel 3 drains.
- Mode switch: round-robin sends 2 words (rr_ptr = 2), switch to sel = 6 and send 1 word, switch back and send 1 word -> words go to channels 0, 1, 6, 2; final rr_ptr = 3.
